// File: rtl/regfile_writer.sv
// Write-side front end for the 32x32 register file: arbitrates ALU and memory
// writebacks onto one write port, buffers losing memory results, tracks pending loads.
module regfile_writer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_we,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  input  logic                       ld_issue,
  input  logic [4:0]                 ld_rd,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_rd,
  input  logic [XLEN-1:0]            mem_data,
  output logic                       mem_ready,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [4:0]                 id_rd,
  output logic                       hazard,
  output logic                       RegWrite,
  output logic [4:0]                 rd,
  output logic [XLEN-1:0]            toReg,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [4:0]      fifo_rd_mem   [DEPTH];
  logic [XLEN-1:0] fifo_data_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic            out_is_mem_reg;
  logic [31:1]     busy_reg, busy_next;
  logic [31:0]     busy_vec;

  logic mem_accept, fifo_nonempty, sel_alu, sel_fifo, sel_bypass, enq, deq;

  // Ready depends on registered occupancy only, never on a same-cycle dequeue.
  assign mem_ready     = rst_n && (level_reg != FULL);
  assign mem_accept    = mem_valid && mem_ready;
  assign fifo_nonempty = (level_reg != '0);
  assign sel_alu       = alu_we && (alu_rd != 5'd0);
  assign sel_fifo      = !sel_alu && fifo_nonempty;
  assign sel_bypass    = !sel_alu && !fifo_nonempty && mem_accept && (mem_rd != 5'd0);
  assign enq           = mem_accept && (mem_rd != 5'd0) && !sel_bypass;
  assign deq           = sel_fifo;
  assign fifo_level    = level_reg;

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd_mem[wr_ptr_reg]   <= mem_rd;
      fifo_data_mem[wr_ptr_reg] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (deq) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({enq, deq})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite       <= 1'b0;
      rd             <= '0;
      toReg          <= '0;
      out_is_mem_reg <= 1'b0;
    end else begin
      out_is_mem_reg <= sel_fifo || sel_bypass;
      if (sel_alu) begin
        RegWrite <= 1'b1;
        rd       <= alu_rd;
        toReg    <= alu_data;
      end else if (sel_fifo) begin
        RegWrite <= 1'b1;
        rd       <= fifo_rd_mem[rd_ptr_reg];
        toReg    <= fifo_data_mem[rd_ptr_reg];
      end else if (sel_bypass) begin
        RegWrite <= 1'b1;
        rd       <= mem_rd;
        toReg    <= mem_data;
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

  // Busy clears on the edge the register file commits a memory value; a new load wins.
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (ld_issue && (ld_rd == 5'(gi))) ? 1'b1 :
                             (RegWrite && out_is_mem_reg && (rd == 5'(gi))) ? 1'b0 :
                             busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  assign busy_vec = {busy_reg, 1'b0};
  assign hazard   = busy_vec[rs1] | busy_vec[rs2] | busy_vec[id_rd];

endmodule
